// File: rtl/dm_port_arbiter.sv
// dm_port_arbiter: CPU-priority arbiter for the shared data-memory port with DMA starvation guard and bounded locked bursts.
// Define ARB_STATS_EN to add saturating grant/force statistics outputs.
module dm_port_arbiter #(
    parameter int MEM_AW     = 12,
    parameter int STARVE_MAX = 4,
    parameter int BURST_MAX  = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cpu_req,
    input  logic [31:0] cpu_addr,
    input  logic [3:0]  cpu_byteen,
    input  logic [31:0] cpu_wdata,
    output logic        cpu_gnt,
    output logic        cpu_rvalid,
    output logic [31:0] cpu_rdata,
    input  logic        dma_req,
    input  logic        dma_lock,
    input  logic [31:0] dma_addr,
    input  logic [3:0]  dma_byteen,
    input  logic [31:0] dma_wdata,
    output logic        dma_gnt,
    output logic        dma_rvalid,
    output logic [31:0] dma_rdata,
`ifdef ARB_STATS_EN
    output logic [31:0] cpu_grant_cnt,
    output logic [31:0] dma_grant_cnt,
    output logic [15:0] force_cnt,
`endif
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_byteen,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);
    typedef enum logic [1:0] {ARB_CPU, ARB_DMA_FORCE, ARB_DMA_LOCK} arb_state_e;

    localparam int SW = $clog2(STARVE_MAX + 1);
    localparam int BW = $clog2(BURST_MAX + 1);
    localparam logic [SW-1:0] STARVE_LAST = SW'(STARVE_MAX - 1);
    localparam logic [BW-1:0] BURST_TOP   = BW'(BURST_MAX);

    arb_state_e    state_q;
    logic [SW-1:0] starve_cnt_q;
    logic [BW-1:0] burst_cnt_q;
    logic          cpu_rvalid_q, dma_rvalid_q;
    logic [31:0]   cpu_rdata_q, dma_rdata_q;
    logic          lock_exit, force_entry, in_range, cpu_rd, dma_rd;
    logic [31:0]   sel_addr, sel_wdata, rd_word;
    logic [3:0]    sel_byteen;

    // In a locked burst the CPU only gets in on the cycle the burst ends or yields.
    assign lock_exit   = !dma_lock || !dma_req || (burst_cnt_q == BURST_TOP && cpu_req);
    assign force_entry = state_q == ARB_CPU && dma_req && !dma_gnt && starve_cnt_q == STARVE_LAST;

    always_comb begin
        cpu_gnt = 1'b0;
        dma_gnt = 1'b0;
        if (reset) begin
            case (state_q)
                ARB_CPU: begin
                    cpu_gnt = cpu_req;
                    dma_gnt = dma_req && !cpu_req;
                end
                ARB_DMA_FORCE: begin
                    dma_gnt = dma_req;
                    cpu_gnt = cpu_req && !dma_req;
                end
                default: begin
                    cpu_gnt = cpu_req && lock_exit;
                    dma_gnt = dma_req && !(cpu_req && lock_exit);
                end
            endcase
        end
    end

    assign sel_addr   = cpu_gnt ? cpu_addr   : dma_gnt ? dma_addr   : 32'h0;
    assign sel_byteen = cpu_gnt ? cpu_byteen : dma_gnt ? dma_byteen : 4'h0;
    assign sel_wdata  = cpu_gnt ? cpu_wdata  : dma_gnt ? dma_wdata  : 32'h0;
    assign in_range   = ~|sel_addr[31:MEM_AW+2];
    assign mem_addr   = sel_addr & 32'hffff_fffc;
    assign mem_byteen = in_range ? sel_byteen : 4'h0;
    assign mem_wdata  = sel_wdata;
    assign rd_word    = in_range ? mem_rdata : 32'h0;
    assign cpu_rd     = cpu_gnt && cpu_byteen == 4'h0;
    assign dma_rd     = dma_gnt && dma_byteen == 4'h0;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ARB_CPU;
            starve_cnt_q <= '0;
            burst_cnt_q  <= '0;
            cpu_rvalid_q <= 1'b0;
            dma_rvalid_q <= 1'b0;
            cpu_rdata_q  <= 32'h0;
            dma_rdata_q  <= 32'h0;
        end else begin
            cpu_rvalid_q <= cpu_rd;
            dma_rvalid_q <= dma_rd;
            if (cpu_rd) cpu_rdata_q <= rd_word;
            if (dma_rd) dma_rdata_q <= rd_word;
            if (dma_gnt) starve_cnt_q <= '0;
            case (state_q)
                ARB_CPU: begin
                    if (dma_gnt && dma_lock) begin
                        state_q     <= ARB_DMA_LOCK;
                        burst_cnt_q <= BW'(1);
                    end else if (force_entry) begin
                        state_q      <= ARB_DMA_FORCE;
                        starve_cnt_q <= '0;
                    end else if (dma_req && !dma_gnt) begin
                        starve_cnt_q <= starve_cnt_q + 1'b1;
                    end
                end
                ARB_DMA_FORCE: begin
                    state_q     <= (dma_gnt && dma_lock) ? ARB_DMA_LOCK : ARB_CPU;
                    burst_cnt_q <= (dma_gnt && dma_lock) ? BW'(1) : '0;
                end
                default: begin
                    if (lock_exit) begin
                        state_q     <= ARB_CPU;
                        burst_cnt_q <= '0;
                    end else if (burst_cnt_q != BURST_TOP) begin
                        burst_cnt_q <= burst_cnt_q + 1'b1;
                    end
                end
            endcase
        end
    end

    assign cpu_rvalid = cpu_rvalid_q;
    assign dma_rvalid = dma_rvalid_q;
    assign cpu_rdata  = cpu_rdata_q;
    assign dma_rdata  = dma_rdata_q;

`ifdef ARB_STATS_EN
    logic [31:0] cpu_grant_cnt_q, dma_grant_cnt_q;
    logic [15:0] force_cnt_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cpu_grant_cnt_q <= 32'h0;
            dma_grant_cnt_q <= 32'h0;
            force_cnt_q     <= 16'h0;
        end else begin
            if (cpu_gnt && cpu_grant_cnt_q != '1) cpu_grant_cnt_q <= cpu_grant_cnt_q + 1'b1;
            if (dma_gnt && dma_grant_cnt_q != '1) dma_grant_cnt_q <= dma_grant_cnt_q + 1'b1;
            if (force_entry && force_cnt_q != '1) force_cnt_q <= force_cnt_q + 1'b1;
        end
    end

    assign cpu_grant_cnt = cpu_grant_cnt_q;
    assign dma_grant_cnt = dma_grant_cnt_q;
    assign force_cnt     = force_cnt_q;
`endif
endmodule

// File: tb/tb_dm_port_arbiter.sv
// tb_dm_port_arbiter: directed checks of dm_port_arbiter against a 4096-word memory model.
module tb_dm_port_arbiter;
    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_req, dma_req, dma_lock;
    logic [31:0] cpu_addr, cpu_wdata, dma_addr, dma_wdata;
    logic [3:0]  cpu_byteen, dma_byteen;
    logic        cpu_gnt, cpu_rvalid, dma_gnt, dma_rvalid;
    logic [31:0] cpu_rdata, dma_rdata, mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_byteen;
`ifdef ARB_STATS_EN
    logic [31:0] cpu_grant_cnt, dma_grant_cnt;
    logic [15:0] force_cnt;
`endif
    logic [31:0] mem [4096];
    int checks = 0;
    int failures = 0;

    dm_port_arbiter dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_addr(cpu_addr), .cpu_byteen(cpu_byteen), .cpu_wdata(cpu_wdata),
        .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
        .dma_req(dma_req), .dma_lock(dma_lock), .dma_addr(dma_addr), .dma_byteen(dma_byteen),
        .dma_wdata(dma_wdata), .dma_gnt(dma_gnt), .dma_rvalid(dma_rvalid), .dma_rdata(dma_rdata),
`ifdef ARB_STATS_EN
        .cpu_grant_cnt(cpu_grant_cnt), .dma_grant_cnt(dma_grant_cnt), .force_cnt(force_cnt),
`endif
        .mem_addr(mem_addr), .mem_byteen(mem_byteen), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // Index wraps on out-of-range addresses, so a leaked write would corrupt word 0.
    assign mem_rdata = mem[mem_addr[13:2]];
    always @(posedge clk)
        for (int b = 0; b < 4; b++)
            if (mem_byteen[b]) mem[mem_addr[13:2]][8*b +: 8] <= mem_wdata[8*b +: 8];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        cpu_req = 1'b0; cpu_addr = 32'h0; cpu_byteen = 4'h0; cpu_wdata = 32'h0;
        dma_req = 1'b0; dma_lock = 1'b0; dma_addr = 32'h0; dma_byteen = 4'h0; dma_wdata = 32'h0;
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) mem[i] = 32'h0;
        mem[0]    = 32'h5555_5555;
        mem[4]    = 32'h1122_3344;
        mem[32'h20] = 32'hDEAD_BEEF;
        reset = 1'b0;
        idle();
        tick();
        cpu_req = 1'b1; cpu_addr = 32'h10; cpu_byteen = 4'hF;
        #1;
        check("rst_cpu_gnt", {31'h0, cpu_gnt}, 32'h0);
        check("rst_mem_byteen", {28'h0, mem_byteen}, 32'h0);
        check("rst_mem_addr", mem_addr, 32'h0);
        check("rst_rvalid", {30'h0, cpu_rvalid, dma_rvalid}, 32'h0);
        check("rst_rdata", cpu_rdata | dma_rdata, 32'h0);
        idle();
        tick();
        reset = 1'b1;

        // Partial-lane CPU write
        cpu_req = 1'b1; cpu_addr = 32'h10; cpu_byteen = 4'b0011; cpu_wdata = 32'hAABB_CCDD;
        #1;
        check("wr_cpu_gnt", {31'h0, cpu_gnt}, 32'h1);
        check("wr_mem_byteen", {28'h0, mem_byteen}, 32'h3);
        tick();
        idle();
        #1;
        check("wr_mem_word4", mem[4], 32'h1122_CCDD);
        check("wr_no_rvalid", {31'h0, cpu_rvalid}, 32'h0);

        // DMA read, one-cycle latency
        dma_req = 1'b1; dma_addr = 32'h80;
        #1;
        check("rd_dma_gnt", {31'h0, dma_gnt}, 32'h1);
        tick();
        idle();
        #1;
        check("rd_dma_rvalid", {31'h0, dma_rvalid}, 32'h1);
        check("rd_dma_rdata", dma_rdata, 32'hDEAD_BEEF);
        tick();
        check("rd_dma_rvalid_drop", {31'h0, dma_rvalid}, 32'h0);
        check("rd_dma_rdata_hold", dma_rdata, 32'hDEAD_BEEF);

        // Contention without lock: CPU x4, DMA x1, repeating
        for (int i = 0; i < 10; i++) begin
            cpu_req = 1'b1; cpu_addr = 32'h0;
            dma_req = 1'b1; dma_addr = 32'h80;
            #1;
            check($sformatf("starve_c%0d", i), {30'h0, cpu_gnt, dma_gnt}, (i % 5 == 4) ? 32'h1 : 32'h2);
            tick();
        end
        idle();
        #1;
        check("starve_cpu_rdata", cpu_rdata, 32'h5555_5555);
        check("starve_dma_rvalid", {31'h0, dma_rvalid}, 32'h1);
`ifdef ARB_STATS_EN
        check("stats_force_cnt", {16'h0, force_cnt}, 32'h2);
`endif

        // Out-of-range write then read
        cpu_req = 1'b1; cpu_addr = 32'h4000; cpu_byteen = 4'hF; cpu_wdata = 32'hCAFE_F00D;
        #1;
        check("oor_wr_gnt", {31'h0, cpu_gnt}, 32'h1);
        check("oor_wr_byteen", {28'h0, mem_byteen}, 32'h0);
        tick();
        cpu_byteen = 4'h0;
        #1;
        check("oor_mem_word0", mem[0], 32'h5555_5555);
        tick();
        idle();
        #1;
        check("oor_rd_rvalid", {31'h0, cpu_rvalid}, 32'h1);
        check("oor_rd_rdata", cpu_rdata, 32'h0);

        // Locked DMA burst of 12 beats, CPU requests from beat 3 until it is served
        for (int c = 1; c <= 13; c++) begin
            dma_req = 1'b1; dma_lock = 1'b1; dma_addr = 32'h80;
            cpu_req = (c >= 3 && c <= 9); cpu_addr = 32'h0;
            #1;
            check($sformatf("burst_c%0d", c), {30'h0, cpu_gnt, dma_gnt}, (c == 9) ? 32'h2 : 32'h1);
            tick();
        end
        check("lock_rvalid_pending", {31'h0, dma_rvalid}, 32'h1);

        // Asynchronous reset in the middle of the locked burst
        reset = 1'b0;
        #1;
        check("mid_rst_rvalid", {31'h0, dma_rvalid}, 32'h0);
        check("mid_rst_gnt", {30'h0, cpu_gnt, dma_gnt}, 32'h0);
        tick();
        reset = 1'b1;
        cpu_req = 1'b1; cpu_addr = 32'h0;
        #1;
        check("post_rst_cpu_wins", {30'h0, cpu_gnt, dma_gnt}, 32'h2);
        idle();
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
